// File: rtl/ascon_pack.sv
// ascon_pack: shared types and constants for the ASCON permutation engine.
//   type_state   five 64-bit words S0..S4; S0 sits in the most significant
//                64 bits of the packed 320-bit vector, S4 in the least.
//   RC_TABLE     the 12 round constants, c_i = F0 - i*0F.
//   SEL_*        rounds_sel encodings.
//   legal_unroll true for rounds-per-clock values that tile every supported
//                round count exactly.
// Build option: ASCON_PERM8_EN adds p8 (rounds 4..11) and narrows the legal
// UNROLL set to {1,2}.
package ascon_pack;

  typedef logic [0:4][63:0] type_state;

  localparam int NUM_ROUNDS = 12;

  localparam logic [1:0] SEL_P12  = 2'b00;
  localparam logic [1:0] SEL_P6   = 2'b01;
  localparam logic [1:0] SEL_P8   = 2'b10;
  localparam logic [1:0] SEL_P12B = 2'b11;

  localparam logic [0:11][7:0] RC_TABLE = {
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

  // 5-bit S-box, index is {x0,x1,x2,x3,x4} with x0 as MSB.
  localparam logic [0:31][4:0] SBOX = {
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  // Out-of-range indices only occur while the engine idles, where the
  // round chain output is discarded.
  function automatic logic [7:0] round_const(logic [3:0] i);
    if (i > 4'd11) return 8'h00;
    return RC_TABLE[i];
  endfunction

  function automatic logic [4:0] sbox5(logic [4:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [63:0] ror64(logic [63:0] x, int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic bit legal_unroll(int u);
`ifdef ASCON_PERM8_EN
    return (u == 1) || (u == 2);
`else
    return (u == 1) || (u == 2) || (u == 3) || (u == 6);
`endif
  endfunction

  // First round index r0 = 12 - N for the selected permutation.
  function automatic logic [3:0] first_round(logic [1:0] sel);
    case (sel)
      SEL_P6:            return 4'd6;
`ifdef ASCON_PERM8_EN
      SEL_P8:            return 4'd4;
`else
      SEL_P8:            return 4'd0;
`endif
      SEL_P12, SEL_P12B: return 4'd0;
      default:           return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ascon_round.sv
// ascon_round: one combinational ASCON round.
//   state  in   320  state before the round
//   round  in   4    round index i (constant c_i goes into S2[7:0])
//   result out  320  state after constant add, S-box layer and linear layer
module ascon_round
  import ascon_pack::*;
(
  input  type_state  state,
  input  logic [3:0] round,
  output type_state  result
);

  type_state added;
  type_state subst;

  // Column-wise S-box: bit c of every word forms one 5-bit column.
  function automatic type_state sbox_layer(type_state a);
    type_state  r;
    logic [4:0] v;
    r = '0;
    for (int c = 0; c < 64; c++) begin
      v = sbox5({a[0][c], a[1][c], a[2][c], a[3][c], a[4][c]});
      {r[0][c], r[1][c], r[2][c], r[3][c], r[4][c]} = v;
    end
    return r;
  endfunction

  always_comb begin
    added          = state;
    added[2][7:0]  = state[2][7:0] ^ round_const(round);
  end

  assign subst = sbox_layer(added);

  assign result[0] = subst[0] ^ ror64(subst[0], 19) ^ ror64(subst[0], 28);
  assign result[1] = subst[1] ^ ror64(subst[1], 61) ^ ror64(subst[1], 39);
  assign result[2] = subst[2] ^ ror64(subst[2],  1) ^ ror64(subst[2],  6);
  assign result[3] = subst[3] ^ ror64(subst[3], 10) ^ ror64(subst[3], 17);
  assign result[4] = subst[4] ^ ror64(subst[4],  7) ^ ror64(subst[4], 41);

endmodule

// File: rtl/ascon_perm_engine.sv
// ascon_perm_engine: multi-cycle ASCON permutation with begin/end XORs and
// cipher/tag registers, UNROLL rounds per clock.
//   clock_i, reset_i       clock, synchronous active-high reset
//   start_i                request, taken only while ready_o=1
//   rounds_sel_i           00/11=p12, 01=p6, 10=p8 (p12 without the option)
//   state_i, data_i, key_i input state S0..S4, rate block, key
//   en_xor_begin_data_i    S0||S1 ^= data_i at load
//   en_xor_begin_key_i     S2||S3 ^= key_i at load
//   en_xor_end_key_i       S3||S4 ^= key after the last round
//   en_xor_end_dom_i       S4[0] ^= 1 after the last round
//   en_reg_cipher_i        cipher_o <= (S0||S1) ^ data_i at load
//   en_reg_tag_i           tag_o <= final S3||S4 after the last round
//   state_o, cipher_o, tag_o  registered results
//   ready_o                idle; done_o one-cycle completion pulse
// Build option: ASCON_PERM8_EN enables p8 (rounds 4..11), UNROLL in {1,2}.
module ascon_perm_engine
  import ascon_pack::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [1:0]   rounds_sel_i,
  input  type_state    state_i,
  input  logic [127:0] data_i,
  input  logic [127:0] key_i,
  input  logic         en_xor_begin_data_i,
  input  logic         en_xor_begin_key_i,
  input  logic         en_xor_end_key_i,
  input  logic         en_xor_end_dom_i,
  input  logic         en_reg_cipher_i,
  input  logic         en_reg_tag_i,
  output type_state    state_o,
  output logic [127:0] cipher_o,
  output logic [127:0] tag_o,
  output logic         ready_o,
  output logic         done_o
);

  if (!legal_unroll(UNROLL)) begin : g_bad_unroll
    $error("ascon_perm_engine: illegal UNROLL=%0d", UNROLL);
  end

  localparam logic [3:0] STEP     = 4'(UNROLL);
  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - UNROLL);

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t         fsm;
  logic [3:0]   rnd;
  logic         end_key_q;
  logic         end_dom_q;
  logic         reg_tag_q;
  // Key is held with the enables so a key change mid-run cannot leak into
  // the end XOR.
  logic [127:0] key_q;

  type_state chain [UNROLL+1];
  type_state load;
  type_state finish;

  assign chain[0] = state_o;

  for (genvar k = 0; k < UNROLL; k++) begin : g_round
    logic [3:0] idx;
    assign idx = rnd + 4'(k);
    ascon_round u_round (
      .state  (chain[k]),
      .round  (idx),
      .result (chain[k+1])
    );
  end

  always_comb begin
    load = state_i;
    if (en_xor_begin_data_i) begin
      load[0] = load[0] ^ data_i[127:64];
      load[1] = load[1] ^ data_i[63:0];
    end
    if (en_xor_begin_key_i) begin
      load[2] = load[2] ^ key_i[127:64];
      load[3] = load[3] ^ key_i[63:0];
    end
  end

  always_comb begin
    finish = chain[UNROLL];
    if (end_key_q) begin
      finish[3] = finish[3] ^ key_q[127:64];
      finish[4] = finish[4] ^ key_q[63:0];
    end
    if (end_dom_q) finish[4][0] = ~finish[4][0];
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm       <= IDLE;
      rnd       <= '0;
      state_o   <= '0;
      cipher_o  <= '0;
      tag_o     <= '0;
      ready_o   <= 1'b1;
      done_o    <= 1'b0;
      end_key_q <= 1'b0;
      end_dom_q <= 1'b0;
      reg_tag_q <= 1'b0;
      key_q     <= '0;
    end else begin
      done_o <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start_i) begin
            fsm       <= RUN;
            ready_o   <= 1'b0;
            rnd       <= first_round(rounds_sel_i);
            state_o   <= load;
            end_key_q <= en_xor_end_key_i;
            end_dom_q <= en_xor_end_dom_i;
            reg_tag_q <= en_reg_tag_i;
            key_q     <= key_i;
            // Cipher always sees the data XOR, independent of the begin XOR.
            if (en_reg_cipher_i) cipher_o <= {state_i[0], state_i[1]} ^ data_i;
          end
        end
        RUN: begin
          if (rnd == LAST_RND) begin
            state_o <= finish;
            if (reg_tag_q) tag_o <= {finish[3], finish[4]};
            fsm     <= IDLE;
            ready_o <= 1'b1;
            done_o  <= 1'b1;
            rnd     <= '0;
          end else begin
            state_o <= chain[UNROLL];
            rnd     <= rnd + STEP;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Bench for ascon_perm_engine: two instances (UNROLL=1 and a wider one)
// share data inputs; each has its own start/reset, expected-result queue and
// monitor. Expected states come from a bit-sliced reference permutation.
module tb_ascon_perm_engine;

`ifdef ASCON_PERM8_EN
  localparam int U_B = 2;
`else
  localparam int U_B = 3;
`endif

  localparam logic [127:0] K     = 128'h691AED630E81901F6CB10AD9CA912F80;
  localparam logic [127:0] NONCE = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] DATA  = 128'h4D20746E75696E65013F206172656E75;
  localparam logic [319:0] S_INIT = {64'h80400c0600000000, K, NONCE};
  localparam logic [319:0] S_A = {64'h0123456789abcdef, 64'hfedcba9876543210,
                                  64'h0f1e2d3c4b5a6978, 64'h8796a5b4c3d2e1f0,
                                  64'h5555aaaa3333cccc};
  localparam logic [319:0] S_B = {64'hdeadbeefcafef00d, 64'h0000000000000001,
                                  64'hffffffffffffffff, 64'h8000000000000000,
                                  64'h13579bdf2468ace0};
  localparam logic [319:0] S_C = {64'h1111111111111111, 64'h2222222222222222,
                                  64'h3333333333333333, 64'h4444444444444444,
                                  64'h5555555555555555};

  typedef struct {
    logic [319:0] st;
    logic [127:0] ci;
    logic [127:0] tg;
    longint       dcyc;
  } exp_t;

  logic         clk;
  logic [1:0]   rst, start, rdy, dn;
  logic [1:0]   sel;
  logic [319:0] sin;
  logic [127:0] din, kin;
  logic [5:0]   en;
  logic [319:0] st [2];
  logic [127:0] ci [2];
  logic [127:0] tg [2];

  exp_t         sb [2][$];
  logic [127:0] mc [2];
  logic [127:0] mt [2];
  logic [319:0] ms [2];
  int           total = 0;
  int           bad = 0;
  longint       cyc = 0;

  ascon_perm_engine #(.UNROLL(1)) u_dut0 (
    .clock_i(clk), .reset_i(rst[0]), .start_i(start[0]), .rounds_sel_i(sel),
    .state_i(sin), .data_i(din), .key_i(kin),
    .en_xor_begin_data_i(en[0]), .en_xor_begin_key_i(en[1]),
    .en_xor_end_key_i(en[2]), .en_xor_end_dom_i(en[3]),
    .en_reg_cipher_i(en[4]), .en_reg_tag_i(en[5]),
    .state_o(st[0]), .cipher_o(ci[0]), .tag_o(tg[0]),
    .ready_o(rdy[0]), .done_o(dn[0])
  );

  ascon_perm_engine #(.UNROLL(U_B)) u_dut1 (
    .clock_i(clk), .reset_i(rst[1]), .start_i(start[1]), .rounds_sel_i(sel),
    .state_i(sin), .data_i(din), .key_i(kin),
    .en_xor_begin_data_i(en[0]), .en_xor_begin_key_i(en[1]),
    .en_xor_end_key_i(en[2]), .en_xor_end_dom_i(en[3]),
    .en_reg_cipher_i(en[4]), .en_reg_tag_i(en[5]),
    .state_o(st[1]), .cipher_o(ci[1]), .tag_o(tg[1]),
    .ready_o(rdy[1]), .done_o(dn[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  function automatic int unroll_of(input int d);
    return (d == 0) ? 1 : U_B;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Bit-sliced reference permutation, rounds r0..11.
  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int r0);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    logic [7:0]  c;
    {x0, x1, x2, x3, x4} = s;
    for (int i = r0; i < 12; i++) begin
      c  = 8'hF0 - 8'(i * 15);
      x2 = x2 ^ {56'h0, c};
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
      x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
      x2 = x2 ^ rotr(x2,  1) ^ rotr(x2,  6);
      x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
      x4 = x4 ^ rotr(x4,  7) ^ rotr(x4, 41);
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  task automatic chk(input int d, input string nm, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d act=%h exp=%h", nm, d, act, exp);
    end
  endtask

  // en: [0]begin data [1]begin key [2]end key [3]end dom [4]reg cipher [5]reg tag
  task automatic issue(input int d, input logic [1:0] s, input logic [319:0] si,
                       input logic [127:0] di, input logic [127:0] ki,
                       input logic [5:0] e, output bit in_done);
    exp_t         x;
    logic [319:0] ld;
    int           r0;
    int           w;
    w = 0;
    while (!rdy[d] && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!rdy[d]) begin
      total++; bad++;
      $display("FAIL ready_timeout dut%0d act=0 exp=1", d);
      in_done = 1'b0;
      return;
    end
    in_done  = dn[d];
    sel      = s; sin = si; din = di; kin = ki; en = e;
    start[d] = 1'b1;
    ld = si;
    if (e[0]) ld[319:192] = ld[319:192] ^ di;
    if (e[1]) ld[191:64]  = ld[191:64] ^ ki;
    if (e[4]) mc[d] = si[319:192] ^ di;
    r0 = (s == 2'b01) ? 6 : 0;
`ifdef ASCON_PERM8_EN
    if (s == 2'b10) r0 = 4;
`endif
    x.st = ref_perm(ld, r0);
    if (e[2]) x.st[127:0] = x.st[127:0] ^ ki;
    if (e[3]) x.st[0] = ~x.st[0];
    if (e[5]) mt[d] = x.st[127:0];
    x.ci   = mc[d];
    x.tg   = mt[d];
    x.dcyc = cyc + 1 + longint'((12 - r0) / unroll_of(d));
    ms[d]  = x.st;
    sb[d].push_back(x);
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int w;
    w = 0;
    while (sb[d].size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sb[d].size() != 0) begin
      total++; bad++;
      $display("FAIL done_timeout dut%0d pending=%0d exp=0", d, sb[d].size());
      sb[d].delete();
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_mon
    always @(negedge clk) begin
      exp_t e;
      if (dn[g]) begin
        if (sb[g].size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done dut%0d act=done exp=none", g);
        end else begin
          e = sb[g].pop_front();
          chk(g, "state", st[g], e.st);
          chk(g, "cipher", 320'(ci[g]), 320'(e.ci));
          chk(g, "tag", 320'(tg[g]), 320'(e.tg));
          chk(g, "done_cycle", 320'(cyc), 320'(e.dcyc));
          chk(g, "ready_with_done", 320'(rdy[g]), 320'd1);
        end
      end
    end
  end

  task automatic run_suite(input int d);
    bit f;
    int pre;
    // p12 initialisation with end key XOR
    issue(d, 2'b00, S_INIT, 128'h0, K, 6'b000100, f);
    wait_idle(d);
    // p6 encryption from zero state: cipher is the plain data block
    issue(d, 2'b01, 320'h0, DATA, K, 6'b010000, f);
    wait_idle(d);
    chk(d, "cipher_eq_data", 320'(ci[d]), 320'(128'h4D20746E75696E65013F206172656E75));
    // finalisation: tag latched and held while idle
    issue(d, 2'b00, S_A, DATA, K, 6'b100110, f);
    wait_idle(d);
    repeat (5) begin
      @(negedge clk);
      chk(d, "tag_hold", 320'(tg[d]), 320'(mt[d]));
      chk(d, "state_hold", st[d], ms[d]);
    end
    // start and input changes mid-run are ignored; sel=11 acts as p12
    issue(d, 2'b11, S_B, DATA, K, 6'b001101, f);
    @(negedge clk);
    chk(d, "ready_low_run", 320'(rdy[d]), 320'd0);
    sel = 2'b01; sin = S_C; en = 6'b111111;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    wait_idle(d);
    // back-to-back: second start lands in the done cycle
    issue(d, 2'b01, S_C, DATA, K, 6'b010011, f);
    issue(d, 2'b10, S_A, DATA, K, 6'b100100, f);
    chk(d, "b2b_start_in_done", 320'(f), 320'd1);
    wait_idle(d);
    // reset mid-run: no done, everything cleared
    issue(d, 2'b00, S_INIT, DATA, K, 6'b100100, f);
    pre = (12 / unroll_of(d) > 5) ? 4 : (12 / unroll_of(d)) - 2;
    repeat (pre) @(negedge clk);
    sb[d].delete(sb[d].size() - 1);
    rst[d] = 1'b1;
    @(negedge clk);
    chk(d, "abort_state", st[d], 320'h0);
    chk(d, "abort_cipher", 320'(ci[d]), 320'h0);
    chk(d, "abort_tag", 320'(tg[d]), 320'h0);
    chk(d, "abort_ready", 320'(rdy[d]), 320'd1);
    chk(d, "abort_done", 320'(dn[d]), 320'd0);
    rst[d] = 1'b0;
    mc[d] = '0;
    mt[d] = '0;
    repeat (16) @(negedge clk);
    chk(d, "abort_idle_ready", 320'(rdy[d]), 320'd1);
    // after reset the cipher register stays cleared when not latched
    issue(d, 2'b01, S_C, DATA, K, 6'b000001, f);
    wait_idle(d);
    chk(d, "cipher_after_reset", 320'(ci[d]), 320'h0);
  endtask

  initial begin
    rst = 2'b11; start = 2'b11; sel = 2'b00;
    sin = S_A; din = DATA; kin = K; en = 6'b111111;
    for (int d = 0; d < 2; d++) begin
      mc[d] = '0; mt[d] = '0; ms[d] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk(d, "rst_state", st[d], 320'h0);
      chk(d, "rst_cipher", 320'(ci[d]), 320'h0);
      chk(d, "rst_tag", 320'(tg[d]), 320'h0);
      chk(d, "rst_ready", 320'(rdy[d]), 320'd1);
      chk(d, "rst_done", 320'(dn[d]), 320'd0);
    end
    rst = 2'b00; start = 2'b00; en = 6'b000000;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk(d, "post_rst_ready", 320'(rdy[d]), 320'd1);
    for (int d = 0; d < 2; d++) run_suite(d);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
